// File: rtl/ppu_fb_writer.sv
`default_nettype none
// ============================================================================
// Module   : ppu_fb_writer
// Purpose  : Converts the PPU background colour-index stream into packed
//            2bpp framebuffer bytes. Each index is mapped through BGP and
//            four shades are packed per byte, first pixel in [7:6]. The
//            x/y raster position produces the byte address y*40 + x/4.
//            Bytes are queued in a small FIFO ahead of a valid/ready write
//            port. FRAME_DONE pulses once the whole frame has been written.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            PX_IN, PX_valid    - colour index and its valid strobe
//            PPU_MODE           - 0=H_BLANK 1=V_BLANK 2=SCAN 3=DRAW
//            BGP                - background palette register
//            FB_WR/ADDR/DATA    - write request, byte address, packed data
//            FB_READY           - memory accepts the write this cycle
//            FRAME_DONE         - one-cycle pulse, frame fully written
//            OVERFLOW           - sticky, a byte was dropped on a full FIFO
// Revision : 1.0 - initial release
// ============================================================================
module ppu_fb_writer #(
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 144,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        PX_IN,
    input  logic              PX_valid,
    input  logic [1:0]        PPU_MODE,
    input  logic [7:0]        BGP,
    output logic              FB_WR,
    output logic [ADDR_W-1:0] FB_ADDR,
    output logic [7:0]        FB_DATA,
    input  logic              FB_READY,
    output logic              FRAME_DONE,
    output logic              OVERFLOW
);

    localparam int c_PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_X_W     = $clog2(WIDTH + 1);
    localparam int c_Y_W     = $clog2(HEIGHT + 1);
    localparam int c_ENTRY_W = ADDR_W + 8;

    localparam logic [1:0] c_ST_ACTIVE = 2'd0;
    localparam logic [1:0] c_ST_FLUSH  = 2'd1;
    localparam logic [1:0] c_ST_DRAIN  = 2'd2;

    // Raster / packing state
    logic [1:0]       r_state;
    logic [1:0]       r_prev_mode;
    logic [c_X_W-1:0] r_x;
    logic [c_Y_W-1:0] r_y;
    logic [1:0]       r_cnt;
    logic [5:0]       r_pack;        // three most recent shades, newest in [1:0]
    logic             r_vblank_flush;
    logic             r_dirty;       // pixel or line seen since last FRAME_DONE
    logic             r_frame_done;

    // Write FIFO
    logic [c_ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;
    logic                 r_overflow;

    logic [1:0]           w_shade;
    logic                 w_line_end;
    logic                 w_vblank_enter;
    logic                 w_accept;
    logic                 w_byte_full;
    logic                 w_flush_push;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_push_ok;
    logic [7:0]           w_flush_data;
    logic [7:0]           w_push_data;
    logic [ADDR_W-1:0]    w_addr;
    logic [c_Y_W-1:0]     w_y_next;
    logic                 w_last_line;
    logic [c_ENTRY_W-1:0] w_head;

    assign w_shade        = BGP[{PX_IN, 1'b0} +: 2];
    assign w_line_end     = (r_prev_mode == 2'd3) && (PPU_MODE == 2'd0);
    assign w_vblank_enter = (r_prev_mode != 2'd1) && (PPU_MODE == 2'd1);
    assign w_accept       = (r_state == c_ST_ACTIVE) && PX_valid && (r_x < c_X_W'(WIDTH));
    assign w_byte_full    = w_accept && (r_cnt == 2'd3);
    assign w_flush_push   = (r_state == c_ST_FLUSH) && (r_cnt != 2'd0);
    assign w_push         = w_byte_full || w_flush_push;

    // y*40 built from shifts. During a partial flush x is 4k+cnt, so x>>2
    // still names the group the partial byte belongs to.
    assign w_addr = ADDR_W'({r_y, 5'b0}) + ADDR_W'({r_y, 3'b0}) + ADDR_W'(r_x >> 2);

    assign w_y_next    = r_y + 1'b1;
    assign w_last_line = (w_y_next == c_Y_W'(HEIGHT));

    // Partial byte is left-aligned and zero-padded
    always_comb begin
        w_flush_data = 8'h00;
        case (r_cnt)
            2'd1:    w_flush_data = {r_pack[1:0], 6'b0};
            2'd2:    w_flush_data = {r_pack[3:0], 4'b0};
            2'd3:    w_flush_data = {r_pack[5:0], 2'b0};
            default: w_flush_data = 8'h00;
        endcase
    end

    assign w_push_data = w_flush_push ? w_flush_data : {r_pack, w_shade};

    assign w_full    = (r_count == (c_PTR_W + 1)'(FIFO_DEPTH));
    assign w_pop     = FB_WR && FB_READY;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign w_push_ok = w_push && (!w_full || w_pop);

    // Raster state machine
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_ST_ACTIVE;
            r_prev_mode    <= 2'd0;
            r_x            <= '0;
            r_y            <= '0;
            r_cnt          <= 2'd0;
            r_pack         <= 6'd0;
            r_vblank_flush <= 1'b0;
            r_dirty        <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            r_prev_mode  <= PPU_MODE;
            r_frame_done <= 1'b0;
            case (r_state)
                c_ST_ACTIVE: begin
                    if (w_accept) begin
                        r_pack  <= {r_pack[3:0], w_shade};
                        r_cnt   <= r_cnt + 1'b1;
                        r_x     <= r_x + 1'b1;
                        r_dirty <= 1'b1;
                    end
                    if (w_line_end) begin
                        r_state        <= c_ST_FLUSH;
                        r_vblank_flush <= 1'b0;
                    end else if (w_vblank_enter) begin
                        r_state        <= c_ST_FLUSH;
                        r_vblank_flush <= 1'b1;
                    end
                end
                c_ST_FLUSH: begin
                    r_x   <= '0;
                    r_cnt <= 2'd0;
                    if (!r_vblank_flush) begin
                        r_y     <= w_y_next;
                        r_dirty <= 1'b1;
                    end
                    if (r_vblank_flush || w_vblank_enter || w_last_line)
                        r_state <= c_ST_DRAIN;
                    else
                        r_state <= c_ST_ACTIVE;
                end
                c_ST_DRAIN: begin
                    if (r_count == '0) begin
                        // Suppress a second pulse when nothing new was drawn
                        r_frame_done <= r_dirty;
                        r_dirty      <= 1'b0;
                        r_y          <= '0;
                        r_state      <= c_ST_ACTIVE;
                    end
                end
                default: r_state <= c_ST_ACTIVE;
            endcase
        end
    end

    // FIFO storage (contents need no reset; r_count qualifies them)
    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= {w_addr, w_push_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && !w_push_ok)
                r_overflow <= 1'b1;
        end
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign FB_WR      = (r_count != '0);
    assign FB_ADDR    = FB_WR ? w_head[c_ENTRY_W-1:8] : '0;
    assign FB_DATA    = FB_WR ? w_head[7:0] : 8'h00;
    assign FRAME_DONE = r_frame_done;
    assign OVERFLOW   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ppu_fb_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ppu_fb_writer
// Purpose  : Self-checking bench for ppu_fb_writer. Stimulus pushes the
//            expected framebuffer writes into a queue; a monitor pops and
//            compares every accepted write and counts FRAME_DONE pulses.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ppu_fb_writer;

    localparam int ADDR_W = 13;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        PX_IN;
    logic              PX_valid;
    logic [1:0]        PPU_MODE;
    logic [7:0]        BGP;
    logic              FB_WR;
    logic [ADDR_W-1:0] FB_ADDR;
    logic [7:0]        FB_DATA;
    logic              FB_READY;
    logic              FRAME_DONE;
    logic              OVERFLOW;

    logic rand_mode;
    logic ready_force;
    logic rnd_bit;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   fd_cnt  = 0;

    always #5 clk = ~clk;

    assign FB_READY = rand_mode ? rnd_bit : ready_force;

    ppu_fb_writer #(
        .WIDTH(160), .HEIGHT(144), .FIFO_DEPTH(8), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .PX_IN(PX_IN), .PX_valid(PX_valid),
        .PPU_MODE(PPU_MODE), .BGP(BGP), .FB_WR(FB_WR), .FB_ADDR(FB_ADDR),
        .FB_DATA(FB_DATA), .FB_READY(FB_READY), .FRAME_DONE(FRAME_DONE),
        .OVERFLOW(OVERFLOW)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic px(input logic [1:0] v);
        PX_valid = 1'b1;
        PX_IN    = v;
        tick();
        PX_valid = 1'b0;
    endtask

    task automatic px4(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c, input logic [1:0] d);
        px(a); px(b); px(c); px(d);
    endtask

    task automatic expect_wr(input int a, input logic [7:0] d);
        exp_t e;
        e.addr = a[ADDR_W-1:0];
        e.data = d;
        q.push_back(e);
    endtask

    task automatic wait_drain(input int max_cycles);
        int i;
        i = 0;
        while (q.size() != 0 && i < max_cycles) begin
            tick();
            i++;
        end
        check("drain_queue_empty", q.size(), 0);
    endtask

    task automatic do_reset();
        rand_mode   = 1'b0;
        ready_force = 1'b0;
        PX_valid    = 1'b0;
        PPU_MODE    = 2'd3;
        q.delete();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [1:0] pal(input logic [7:0] bgp, input logic [1:0] i);
        logic [7:0] s;
        s = bgp >> (2 * i);
        return s[1:0];
    endfunction

    logic [7:0] fb;
    logic [1:0] fi;
    int         t;

    initial begin
        rst = 1'b1; PX_valid = 1'b0; PX_IN = 2'd0; PPU_MODE = 2'd3; BGP = 8'hE4;
        rand_mode = 1'b0; ready_force = 1'b0; rnd_bit = 1'b0;

        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (FB_WR && FB_READY) begin
                        if (q.size() == 0) begin
                            n_total++;
                            $display("FAIL unexpected_write: actual addr %0d data 0x%02h required no write", FB_ADDR, FB_DATA);
                        end else begin
                            e = q.pop_front();
                            check("write_addr", 32'(FB_ADDR), 32'(e.addr));
                            check("write_data", 32'(FB_DATA), 32'(e.data));
                        end
                    end
                    if (FRAME_DONE) begin
                        fd_cnt++;
                        check("frame_done_after_last_write", q.size(), 0);
                    end
                end
            end
            begin : ready_gen
                forever begin
                    @(posedge clk);
                    #2;
                    rnd_bit = 1'($urandom_range(0, 1));
                end
            end
        join_none

        // Reset state
        tick(); tick();
        check("reset_outputs", {FB_WR, FRAME_DONE, OVERFLOW, FB_ADDR, FB_DATA}, '0);
        rst = 1'b0;

        // 1: identity palette, first write latency
        do_reset();
        BGP = 8'hE4; ready_force = 1'b1;
        expect_wr(0, 8'hE4);
        px(3); px(2); px(1);
        check("wr_low_before_4th", FB_WR, 0);
        px(0);
        check("wr_after_4th", FB_WR, 1);
        check("first_addr", FB_ADDR, 0);
        check("first_data", FB_DATA, 32'hE4);
        wait_drain(20);

        // 2: inverted palette
        do_reset();
        BGP = 8'h1B; ready_force = 1'b1;
        expect_wr(0, 8'hFF);
        px4(0, 0, 0, 0);
        expect_wr(1, 8'h00);
        px4(3, 3, 3, 3);
        wait_drain(20);

        // 3: overflow on 9th byte with stalled memory
        do_reset();
        BGP = 8'hE4;
        for (int k = 0; k < 9; k++) begin
            logic [7:0] kk;
            kk = k[7:0];
            if (k < 8) expect_wr(k, {kk[1:0], kk[3:2], 4'b0011});
            px4(kk[1:0], kk[3:2], 2'd0, 2'd3);
        end
        check("overflow_set", OVERFLOW, 1);
        ready_force = 1'b1;
        wait_drain(50);
        repeat (10) tick();
        check("overflow_sticky", OVERFLOW, 1);

        // 4: partial byte flush on DRAW->H_BLANK, pixel in the same cycle
        do_reset();
        BGP = 8'hE4; ready_force = 1'b1;
        expect_wr(0, 8'h6C);
        expect_wr(1, 8'h90);
        px4(1, 2, 3, 0);
        px(2);
        PPU_MODE = 2'd0;
        px(1);
        tick(); tick();
        PPU_MODE = 2'd3;
        expect_wr(40, 8'hFF);
        px4(3, 3, 3, 3);
        wait_drain(20);

        // 5: full frame with random backpressure
        do_reset();
        BGP = 8'h2D; rand_mode = 1'b1;
        fd_cnt = 0;
        for (int y = 0; y < 144; y++) begin
            fb = 8'h00;
            for (int x = 0; x < 160; x++) begin
                fi = 2'((x ^ (x >> 3) ^ y) & 3);
                fb = {fb[5:0], pal(BGP, fi)};
                if (x % 4 == 3) expect_wr(y * 40 + x / 4, fb);
                px(fi);
            end
            PPU_MODE = 2'd0;
            tick(); tick();
            PPU_MODE = 2'd3;
        end
        wait_drain(400);
        t = 0;
        while (fd_cnt == 0 && t < 200) begin
            tick();
            t++;
        end
        check("frame_done_seen", fd_cnt, 1);
        PPU_MODE = 2'd1;
        repeat (10) tick();
        check("frame_done_single", fd_cnt, 1);
        check("frame_no_overflow", OVERFLOW, 0);
        PPU_MODE = 2'd3;
        tick();
        expect_wr(0, {pal(BGP, 2'd1), pal(BGP, 2'd2), pal(BGP, 2'd3), pal(BGP, 2'd0)});
        px4(1, 2, 3, 0);
        wait_drain(200);

        // 6: reset with queued bytes discards them
        do_reset();
        BGP = 8'hE4;
        px4(1, 1, 1, 1); px4(2, 2, 2, 2); px4(3, 3, 3, 3);
        check("queued_before_rst", FB_WR, 1);
        rst = 1'b1;
        tick();
        check("wr_low_after_rst", FB_WR, 0);
        rst = 1'b0;
        ready_force = 1'b1;
        repeat (10) tick();
        check("no_overflow_after_rst", OVERFLOW, 0);
        expect_wr(0, 8'h55);
        px4(1, 1, 1, 1);
        wait_drain(20);
        repeat (5) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
